// File: rtl/axi_pkg.sv
// Shared AXI-lite bus widths and arbiter types. Bus-width macros (AXI_ADDR_BUS,
// AXI_DATA_BUS, AXI_RESP_BUS, AXI_WSTRB_BUS) are defined here for every file that follows.
`ifndef AXI_ADDR_BUS
`define AXI_ADDR_BUS 32
`endif
`ifndef AXI_DATA_BUS
`define AXI_DATA_BUS 32
`endif
`ifndef AXI_RESP_BUS
`define AXI_RESP_BUS 2
`endif
`ifndef AXI_WSTRB_BUS
`define AXI_WSTRB_BUS 4
`endif

package axi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_IFU = 2'd1,
        RD_LSU = 2'd2,
        WR_LSU = 2'd3
    } arb_state_e;

    localparam logic [`AXI_RESP_BUS-1:0] AXI_RESP_OKAY = 2'b00;

    // Round-robin pointer encoding: which master won the most recent read grant.
    localparam logic RR_IFU = 1'b0;
    localparam logic RR_LSU = 1'b1;

endpackage

// File: rtl/arbiter.sv
// Two-master (IFU, LSU) to one AXI-lite xbar arbiter, one transaction in flight.
// Define ARBITER_RR_EN for round-robin read grants; default is fixed LSU-over-IFU.
module arbiter
    import axi_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic [`AXI_ADDR_BUS-1:0]    ifu_araddr,
    input  logic                        ifu_arvalid,
    output logic                        ifu_arready,
    output logic [`AXI_DATA_BUS-1:0]    ifu_rdata,
    output logic [`AXI_RESP_BUS-1:0]    ifu_rresp,
    output logic                        ifu_rvalid,
    input  logic                        ifu_rready,

    input  logic [`AXI_ADDR_BUS-1:0]    lsu_araddr,
    input  logic                        lsu_arvalid,
    output logic                        lsu_arready,
    output logic [`AXI_DATA_BUS-1:0]    lsu_rdata,
    output logic [`AXI_RESP_BUS-1:0]    lsu_rresp,
    output logic                        lsu_rvalid,
    input  logic                        lsu_rready,
    input  logic [`AXI_ADDR_BUS-1:0]    lsu_awaddr,
    input  logic                        lsu_awvalid,
    output logic                        lsu_awready,
    input  logic [`AXI_DATA_BUS-1:0]    lsu_wdata,
    input  logic [`AXI_WSTRB_BUS-1:0]   lsu_wstrb,
    input  logic                        lsu_wvalid,
    output logic                        lsu_wready,
    output logic [`AXI_RESP_BUS-1:0]    lsu_bresp,
    output logic                        lsu_bvalid,
    input  logic                        lsu_bready,

    output logic [`AXI_ADDR_BUS-1:0]    arbiter_xbar_araddr,
    output logic                        arbiter_xbar_arvalid,
    input  logic                        arbiter_xbar_arready,
    input  logic [`AXI_DATA_BUS-1:0]    arbiter_xbar_rdata,
    input  logic [`AXI_RESP_BUS-1:0]    arbiter_xbar_rresp,
    input  logic                        arbiter_xbar_rvalid,
    output logic                        arbiter_xbar_rready,
    output logic [`AXI_ADDR_BUS-1:0]    arbiter_xbar_awaddr,
    output logic                        arbiter_xbar_awvalid,
    input  logic                        arbiter_xbar_awready,
    output logic [`AXI_DATA_BUS-1:0]    arbiter_xbar_wdata,
    output logic [`AXI_WSTRB_BUS-1:0]   arbiter_xbar_wstrb,
    output logic                        arbiter_xbar_wvalid,
    input  logic                        arbiter_xbar_wready,
    input  logic [`AXI_RESP_BUS-1:0]    arbiter_xbar_bresp,
    input  logic                        arbiter_xbar_bvalid,
    output logic                        arbiter_xbar_bready
);

    arb_state_e state_q, state_d;
    logic       ar_done_q, ar_done_d;
    logic       rd_pick_lsu;

`ifdef ARBITER_RR_EN
    logic       rr_last_q;

    // On a tie the master that did not win last time gets the read.
    assign rd_pick_lsu = (lsu_arvalid && ifu_arvalid) ? (rr_last_q == RR_IFU) : lsu_arvalid;
`else
    assign rd_pick_lsu = lsu_arvalid;
`endif

    always_comb begin
        state_d   = state_q;
        ar_done_d = ar_done_q;
        unique case (state_q)
            IDLE: begin
                ar_done_d = 1'b0;
                if (lsu_awvalid || lsu_wvalid) begin
                    state_d = WR_LSU;
                end else if (lsu_arvalid || ifu_arvalid) begin
                    state_d = rd_pick_lsu ? RD_LSU : RD_IFU;
                end
            end
            RD_IFU, RD_LSU: begin
                if (arbiter_xbar_arvalid && arbiter_xbar_arready) begin
                    ar_done_d = 1'b1;
                end
                if (arbiter_xbar_rvalid && arbiter_xbar_rready) begin
                    state_d = IDLE;
                end
            end
            WR_LSU: begin
                if (arbiter_xbar_bvalid && arbiter_xbar_bready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ar_done_q <= 1'b0;
`ifdef ARBITER_RR_EN
            rr_last_q <= RR_IFU;
`endif
        end else begin
            state_q   <= state_d;
            ar_done_q <= ar_done_d;
`ifdef ARBITER_RR_EN
            if (state_q == IDLE && (state_d == RD_IFU || state_d == RD_LSU)) begin
                rr_last_q <= (state_d == RD_LSU) ? RR_LSU : RR_IFU;
            end
`endif
        end
    end

    // Pure routing from the registered state; everything not owned by the grant stays 0.
    always_comb begin
        ifu_arready          = 1'b0;
        ifu_rdata            = '0;
        ifu_rresp            = AXI_RESP_OKAY;
        ifu_rvalid           = 1'b0;
        lsu_arready          = 1'b0;
        lsu_rdata            = '0;
        lsu_rresp            = AXI_RESP_OKAY;
        lsu_rvalid           = 1'b0;
        lsu_awready          = 1'b0;
        lsu_wready           = 1'b0;
        lsu_bresp            = AXI_RESP_OKAY;
        lsu_bvalid           = 1'b0;
        arbiter_xbar_araddr  = '0;
        arbiter_xbar_arvalid = 1'b0;
        arbiter_xbar_rready  = 1'b0;
        arbiter_xbar_awaddr  = '0;
        arbiter_xbar_awvalid = 1'b0;
        arbiter_xbar_wdata   = '0;
        arbiter_xbar_wstrb   = '0;
        arbiter_xbar_wvalid  = 1'b0;
        arbiter_xbar_bready  = 1'b0;
        unique case (state_q)
            RD_IFU: begin
                arbiter_xbar_araddr  = ifu_araddr;
                arbiter_xbar_arvalid = ifu_arvalid && !ar_done_q;
                ifu_arready          = arbiter_xbar_arready && !ar_done_q;
                ifu_rdata            = arbiter_xbar_rdata;
                ifu_rresp            = arbiter_xbar_rresp;
                ifu_rvalid           = arbiter_xbar_rvalid;
                arbiter_xbar_rready  = ifu_rready;
            end
            RD_LSU: begin
                arbiter_xbar_araddr  = lsu_araddr;
                arbiter_xbar_arvalid = lsu_arvalid && !ar_done_q;
                lsu_arready          = arbiter_xbar_arready && !ar_done_q;
                lsu_rdata            = arbiter_xbar_rdata;
                lsu_rresp            = arbiter_xbar_rresp;
                lsu_rvalid           = arbiter_xbar_rvalid;
                arbiter_xbar_rready  = lsu_rready;
            end
            WR_LSU: begin
                arbiter_xbar_awaddr  = lsu_awaddr;
                arbiter_xbar_awvalid = lsu_awvalid;
                lsu_awready          = arbiter_xbar_awready;
                arbiter_xbar_wdata   = lsu_wdata;
                arbiter_xbar_wstrb   = lsu_wstrb;
                arbiter_xbar_wvalid  = lsu_wvalid;
                lsu_wready           = arbiter_xbar_wready;
                lsu_bresp            = arbiter_xbar_bresp;
                lsu_bvalid           = arbiter_xbar_bvalid;
                arbiter_xbar_bready  = lsu_bready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_arbiter.sv
// Directed bench for arbiter: behavioural xbar slave plus a response scoreboard.
// Grant-order expectations follow ARBITER_RR_EN when it is defined.
module tb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        slaveRstN;

    logic [31:0] ifu_araddr;
    logic        ifu_arvalid, ifu_arready;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rvalid, ifu_rready;
    logic [31:0] lsu_araddr;
    logic        lsu_arvalid, lsu_arready;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_rvalid, lsu_rready;
    logic [31:0] lsu_awaddr;
    logic        lsu_awvalid, lsu_awready;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic        lsu_wvalid, lsu_wready;
    logic [1:0]  lsu_bresp;
    logic        lsu_bvalid, lsu_bready;

    logic [31:0] xAraddr;
    logic        xArvalid, xArready;
    logic [31:0] xRdata;
    logic [1:0]  xRresp;
    logic        xRvalid, xRready;
    logic [31:0] xAwaddr;
    logic        xAwvalid, xAwready;
    logic [31:0] xWdata;
    logic [3:0]  xWstrb;
    logic        xWvalid, xWready;
    logic [1:0]  xBresp;
    logic        xBvalid, xBready;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] data;
        logic [1:0]  resp;
    } expect_t;

    expect_t sbQueue[$];
    int      vectors     = 0;
    int      miscompares = 0;
    int      rdLatency   = 2;

    always #5 clk = ~clk;

    arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .arbiter_xbar_araddr(xAraddr), .arbiter_xbar_arvalid(xArvalid), .arbiter_xbar_arready(xArready),
        .arbiter_xbar_rdata(xRdata), .arbiter_xbar_rresp(xRresp), .arbiter_xbar_rvalid(xRvalid),
        .arbiter_xbar_rready(xRready),
        .arbiter_xbar_awaddr(xAwaddr), .arbiter_xbar_awvalid(xAwvalid), .arbiter_xbar_awready(xAwready),
        .arbiter_xbar_wdata(xWdata), .arbiter_xbar_wstrb(xWstrb), .arbiter_xbar_wvalid(xWvalid),
        .arbiter_xbar_wready(xWready),
        .arbiter_xbar_bresp(xBresp), .arbiter_xbar_bvalid(xBvalid), .arbiter_xbar_bready(xBready)
    );

    function automatic logic [31:0] memModel(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [1:0] respModel(input logic [31:0] a);
        return a[5:4];
    endfunction

    // Xbar read slave: one read at a time, rdLatency idle cycles before R.
    logic        sRdBusy;
    logic [31:0] sRdAddr;
    int          sRdWait;
    assign xArready = !sRdBusy;

    always @(posedge clk) begin
        if (!slaveRstN) begin
            sRdBusy <= 1'b0;
            sRdWait <= 0;
            sRdAddr <= '0;
            xRvalid <= 1'b0;
            xRdata  <= '0;
            xRresp  <= '0;
        end else if (xArvalid && xArready) begin
            sRdBusy <= 1'b1;
            sRdAddr <= xAraddr;
            sRdWait <= rdLatency;
        end else if (sRdBusy && !xRvalid) begin
            if (sRdWait == 0) begin
                xRvalid <= 1'b1;
                xRdata  <= memModel(sRdAddr);
                xRresp  <= respModel(sRdAddr);
            end else begin
                sRdWait <= sRdWait - 1;
            end
        end else if (xRvalid && xRready) begin
            xRvalid <= 1'b0;
            sRdBusy <= 1'b0;
        end
    end

    // Xbar write slave: takes AW and W in any order, answers B once both have arrived.
    logic        sAwGot, sWGot;
    logic [31:0] sWData;
    assign xAwready = !sAwGot;
    assign xWready  = !sWGot;

    always @(posedge clk) begin
        if (!slaveRstN) begin
            sAwGot  <= 1'b0;
            sWGot   <= 1'b0;
            sWData  <= '0;
            xBvalid <= 1'b0;
            xBresp  <= '0;
        end else begin
            if (xAwvalid && xAwready) sAwGot <= 1'b1;
            if (xWvalid && xWready) begin
                sWGot  <= 1'b1;
                sWData <= xWdata;
            end
            if (sAwGot && sWGot && !xBvalid) begin
                xBvalid <= 1'b1;
                xBresp  <= sWData[1:0];
            end
            if (xBvalid && xBready) begin
                xBvalid <= 1'b0;
                sAwGot  <= 1'b0;
                sWGot   <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic scoreCheck(input logic [1:0] kind, input logic [31:0] data, input logic [1:0] resp);
        expect_t e;
        if (sbQueue.size() == 0) begin
            checkOutput("sbUnexpected", 32'(sbQueue.size()), 32'd1);
        end else begin
            e = sbQueue.pop_front();
            checkOutput("sbKind", 32'(kind), 32'(e.kind));
            if (kind != 2'd2) checkOutput("sbData", data, e.data);
            checkOutput("sbResp", 32'(resp), 32'(e.resp));
        end
    endtask

    // Response monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ifu_rvalid && ifu_rready) scoreCheck(2'd0, ifu_rdata, ifu_rresp);
            if (lsu_rvalid && lsu_rready) scoreCheck(2'd1, lsu_rdata, lsu_rresp);
            if (lsu_bvalid && lsu_bready) scoreCheck(2'd2, 32'h0, lsu_bresp);
        end
    end

    task automatic pushRead(input logic isLsu, input logic [31:0] addr);
        expect_t e;
        e.kind = isLsu ? 2'd1 : 2'd0;
        e.data = memModel(addr);
        e.resp = respModel(addr);
        sbQueue.push_back(e);
    endtask

    // Starts the next cycle, drives every request input, then lets outputs settle.
    task automatic applyStimulus(input logic ifuV, input logic [31:0] ifuA,
                                 input logic lsuV, input logic [31:0] lsuA,
                                 input logic awV, input logic [31:0] awA, input logic wV);
        @(posedge clk);
        #2;
        ifu_arvalid = ifuV;
        ifu_araddr  = ifuA;
        lsu_arvalid = lsuV;
        lsu_araddr  = lsuA;
        lsu_awvalid = awV;
        lsu_awaddr  = awA;
        lsu_wvalid  = wV;
        #1;
    endtask

    // which: 0 = IFU R, 1 = LSU R, 2 = LSU B; holds current inputs while waiting.
    task automatic waitResp(input int which, input string tag);
        int n = 0;
        logic seen;
        seen = (which == 0) ? ifu_rvalid : (which == 1) ? lsu_rvalid : lsu_bvalid;
        while (!seen && n < 30) begin
            @(posedge clk);
            #3;
            n++;
            seen = (which == 0) ? ifu_rvalid : (which == 1) ? lsu_rvalid : lsu_bvalid;
        end
        checkOutput(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        logic        lsuWins;
        logic [31:0] ia, la;

        rst_n       = 1'b0;
        slaveRstN   = 1'b0;
        ifu_araddr  = '0; ifu_arvalid = 1'b0; ifu_rready = 1'b1;
        lsu_araddr  = '0; lsu_arvalid = 1'b0; lsu_rready = 1'b1;
        lsu_awaddr  = '0; lsu_awvalid = 1'b0;
        lsu_wdata   = 32'h0000_0041; lsu_wstrb = 4'b0001; lsu_wvalid = 1'b0;
        lsu_bready  = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_n     = 1'b1;
        slaveRstN = 1'b1;
        #1;

        // Idle after reset: slave is ready, but nothing may leak through.
        checkOutput("rstArvalid", 32'(xArvalid), 32'd0);
        checkOutput("rstIfuArready", 32'(ifu_arready), 32'd0);
        checkOutput("rstLsuAwready", 32'(lsu_awready), 32'd0);
        checkOutput("rstRready", 32'(xRready), 32'd0);
        checkOutput("rstBready", 32'(xBready), 32'd0);

        // Lone IFU read with one-cycle grant latency and a second AR attempt.
        applyStimulus(1'b1, 32'h8000_0000, 1'b0, '0, 1'b0, '0, 1'b0);
        pushRead(1'b0, 32'h8000_0000);
        checkOutput("ifuIdleArvalid", 32'(xArvalid), 32'd0);
        applyStimulus(1'b1, 32'h8000_0000, 1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("ifuGrantArvalid", 32'(xArvalid), 32'd1);
        checkOutput("ifuGrantAraddr", xAraddr, 32'h8000_0000);
        checkOutput("ifuGrantArready", 32'(ifu_arready), 32'd1);
        checkOutput("ifuGrantLsuArready", 32'(lsu_arready), 32'd0);
        applyStimulus(1'b1, 32'h8000_0000, 1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("ifuArDoneMask", 32'(xArvalid), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        waitResp(0, "ifuRvalidTimeout");
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("ifuIdleRready", 32'(xRready), 32'd0);

        // Collision: LSU first, IFU held off until the LSU R handshake.
        applyStimulus(1'b1, 32'h8000_0020, 1'b1, 32'hA000_0030, 1'b0, '0, 1'b0);
        pushRead(1'b1, 32'hA000_0030);
        pushRead(1'b0, 32'h8000_0020);
        applyStimulus(1'b1, 32'h8000_0020, 1'b1, 32'hA000_0030, 1'b0, '0, 1'b0);
        checkOutput("colLsuAraddr", xAraddr, 32'hA000_0030);
        checkOutput("colLsuArready", 32'(lsu_arready), 32'd1);
        checkOutput("colIfuArready", 32'(ifu_arready), 32'd0);
        applyStimulus(1'b1, 32'h8000_0020, 1'b0, '0, 1'b0, '0, 1'b0);
        waitResp(1, "colLsuRvalidTimeout");
        checkOutput("colIfuHeld", 32'(ifu_arready), 32'd0);
        applyStimulus(1'b1, 32'h8000_0020, 1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("colIdleIfuArready", 32'(ifu_arready), 32'd0);
        applyStimulus(1'b1, 32'h8000_0020, 1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("colIfuAraddr", xAraddr, 32'h8000_0020);
        checkOutput("colIfuArready", 32'(ifu_arready), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        waitResp(0, "colIfuRvalidTimeout");
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);

        // Three back-to-back collisions; the last grant above went to IFU.
        for (int k = 0; k < 3; k++) begin
            ia = 32'h8000_0100 + 32'(k * 16);
            la = 32'hA000_0100 + 32'(k * 16);
`ifdef ARBITER_RR_EN
            lsuWins = (k % 2 == 0);
`else
            lsuWins = 1'b1;
`endif
            applyStimulus(1'b1, ia, 1'b1, la, 1'b0, '0, 1'b0);
            pushRead(lsuWins, lsuWins ? la : ia);
            applyStimulus(1'b1, ia, 1'b1, la, 1'b0, '0, 1'b0);
            checkOutput($sformatf("rrGrant%0d", k), xAraddr, lsuWins ? la : ia);
            applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
            waitResp(lsuWins ? 1 : 0, $sformatf("rrRvalidTimeout%0d", k));
            applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        end

        // LSU write (W before AW) competing with an LSU read: write goes first.
        applyStimulus(1'b0, '0, 1'b1, 32'hA000_0040, 1'b0, '0, 1'b1);
        begin
            expect_t e;
            e.kind = 2'd2; e.data = '0; e.resp = 2'b01;
            sbQueue.push_back(e);
        end
        pushRead(1'b1, 32'hA000_0040);
        checkOutput("wrIdleWready", 32'(lsu_wready), 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 32'hA000_0040, 1'b0, '0, 1'b1);
        checkOutput("wrWvalid", 32'(xWvalid), 32'd1);
        checkOutput("wrWdata", xWdata, 32'h0000_0041);
        checkOutput("wrWstrb", 32'(xWstrb), 32'h1);
        checkOutput("wrWready", 32'(lsu_wready), 32'd1);
        checkOutput("wrAwvalidEarly", 32'(xAwvalid), 32'd0);
        checkOutput("wrAraddrW", xAraddr, 32'd0);
        checkOutput("wrArvalid", 32'(xArvalid), 32'd0);
        checkOutput("wrLsuArready", 32'(lsu_arready), 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 32'hA000_0040, 1'b1, 32'hA000_03F8, 1'b0);
        checkOutput("wrAwaddr", xAwaddr, 32'hA000_03F8);
        checkOutput("wrAwvalid", 32'(xAwvalid), 32'd1);
        checkOutput("wrAwready", 32'(lsu_awready), 32'd1);
        checkOutput("wrAraddrAw", xAraddr, 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 32'hA000_0040, 1'b0, '0, 1'b0);
        waitResp(2, "wrBvalidTimeout");
        checkOutput("wrAraddrB", xAraddr, 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 32'hA000_0040, 1'b0, '0, 1'b0);
        checkOutput("wrIdleBvalid", 32'(lsu_bvalid), 32'd0);
        checkOutput("wrIdleBready", 32'(xBready), 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 32'hA000_0040, 1'b0, '0, 1'b0);
        checkOutput("wrThenReadAraddr", xAraddr, 32'hA000_0040);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        waitResp(1, "wrReadRvalidTimeout");
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);

        // Reset in RD_LSU after AR, while the slave is about to raise R.
        rdLatency = 0;
        applyStimulus(1'b0, '0, 1'b1, 32'hA000_0050, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 32'hA000_0050, 1'b0, '0, 1'b0);
        checkOutput("rstMidArvalid", 32'(xArvalid), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        checkOutput("rstMidSlaveRvalid", 32'(xRvalid), 32'd1);
        checkOutput("rstMidLsuRvalid", 32'(lsu_rvalid), 32'd0);
        checkOutput("rstMidRready", 32'(xRready), 32'd0);
        checkOutput("rstMidAraddr", xAraddr, 32'd0);
        checkOutput("rstMidXbarValids", {28'd0, xArvalid, xAwvalid, xWvalid, xBready}, 32'd0);
        checkOutput("rstMidLsuArready", 32'(lsu_arready), 32'd0);
        @(posedge clk);
        #2;
        slaveRstN = 1'b0;
        @(posedge clk);
        #2;
        slaveRstN = 1'b1;
        rdLatency = 1;

        // Normal service resumes after reset.
        applyStimulus(1'b1, 32'h8000_0070, 1'b0, '0, 1'b0, '0, 1'b0);
        pushRead(1'b0, 32'h8000_0070);
        applyStimulus(1'b1, 32'h8000_0070, 1'b0, '0, 1'b0, '0, 1'b0);
        checkOutput("postRstAraddr", xAraddr, 32'h8000_0070);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        waitResp(0, "postRstRvalidTimeout");
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);

        checkOutput("sbDrained", 32'(sbQueue.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arbiter.md
ARBITER -- requirements
Module: arbiter

Interface
REQ-001 Parameters SHALL be none; widths SHALL come from defines.svh: `AXI_ADDR_BUS 32b, `AXI_DATA_BUS 32b, `AXI_RESP_BUS 2b, `AXI_WSTRB_BUS 4b.
REQ-002 Clocking SHALL use one clock `clk`; reset `rst_n` is synchronous and active-low.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  sync active-low reset
- ifu_araddr/arvalid/arready  in/in/out  32/1/1  IFU (m0) read address
- ifu_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  IFU read data
- lsu_araddr/arvalid/arready  in/in/out  32/1/1  LSU (m1) read address
- lsu_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  LSU read data
- lsu_awaddr/awvalid/awready  in/in/out  32/1/1  LSU write address
- lsu_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  LSU write data
- lsu_bresp/bvalid/bready  out/out/in  2/1/1  LSU write response
- arbiter_xbar_{araddr,arvalid,arready,rdata,rresp,rvalid,rready,awaddr,awvalid,awready,wdata,wstrb,wvalid,wready,bresp,bvalid,bready}  master side toward xbar, AXI-lite directions, same widths.

Function
REQ-004 FSM states SHALL be IDLE, RD_IFU, RD_LSU, WR_LSU; state register only, routing combinational from state.
REQ-005 In IDLE, the block SHALL assert no valid/ready toward any side; all arbiter_xbar_* outputs 0.
REQ-006 IDLE grant priority SHALL be: lsu_awvalid|lsu_wvalid -> WR_LSU; else read select per REQ-014; else stay IDLE.
REQ-007 Grant latency SHALL be one cycle: request sampled in IDLE, forwarded to xbar in the granted state the next cycle.
REQ-008 In RD_x, the granted master's AR/R SHALL be wired straight to arbiter_xbar AR/R; arbiter_xbar_awaddr/awvalid/wvalid/bready SHALL be 0 (xbar decodes on araddr|awaddr).
REQ-009 In WR_LSU, LSU AW/W/B SHALL be wired to arbiter_xbar; arbiter_xbar_araddr/arvalid/rready SHALL be 0; AW and W handshakes independent, either order.
REQ-010 Return to IDLE SHALL occur on the cycle after the R handshake (rvalid&&rready) in RD_x, or B handshake (bvalid&&bready) in WR_LSU; no back-to-back grant without passing IDLE.
REQ-011 The ungranted master SHALL see arready/awready/wready/rvalid/bvalid=0, rdata/rresp/bresp=0.
REQ-012 One outstanding transaction SHALL be allowed system-wide; a second AR from the granted master after its AR handshake SHALL not be accepted (arready forced 0 once AR handshake done, tracked by 1b flag cleared on IDLE).
REQ-013 Simultaneous IFU and LSU read in IDLE SHALL resolve per REQ-014; LSU read+write simultaneous SHALL take write first.

Configuration
REQ-014 With ARBITER_RR_EN defined, read grant SHALL be round-robin: 1b last-read pointer, updated on entering RD_x, reset to IFU-last (LSU wins first tie); without it, fixed priority LSU read over IFU read.

Reset
REQ-015 On rst_n=0 at a clk edge, state SHALL go IDLE, AR-done flag and RR pointer cleared, regardless of in-flight transaction; all outputs SHALL be 0 in the following cycle.

Structure
REQ-016 arb_state_e enum and AXI_RESP_OKAY=2'b00 SHALL live in shared package axi_pkg.
REQ-017 No sub-module; single-file FSM plus combinational mux.

Verification
REQ-018 IFU read 0x8000_0000 alone -> arbiter_xbar_arvalid at cycle+1, rdata returned to ifu_rdata, state IDLE after R handshake.
REQ-019 IFU and LSU read same cycle, macro off -> LSU granted, IFU arready=0 until LSU R handshake, then IFU granted.
REQ-020 Same with ARBITER_RR_EN, three repeated collisions -> grant order LSU, IFU, LSU.
REQ-021 LSU write 0xa000_03f8 wdata 0x41 wstrb 4'b0001 with W before AW -> both forwarded, araddr=0 throughout, lsu_bvalid on B, then IDLE.
REQ-022 rst_n low mid RD_LSU (after AR, before R) -> next cycle state IDLE, all arbiter_xbar_* 0, lsu_rvalid 0.
